// File: rtl/uart_data_pkg.sv
// Shared types and helpers for the record-to-ASCII UART transmitter.
// Holds the FSM state encoding, the fixed separator bytes and the hex-digit mapping.
package uart_data_pkg;

   typedef enum logic [3:0] {
      IDLE,
      READ_FIFO,
      UART_SEND_WORD,
      UART_WAIT_WORD,
      UART_SEND_COMMA,
      UART_WAIT_COMMA,
      UART_SEND_CR,
      UART_WAIT_CR,
      UART_SEND_LF,
      UART_WAIT_LF
   } state_t;

   localparam logic [7:0] ASCII_COMMA = 8'h2C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam int WORD_BITS        = 32;
   localparam int NIBBLES_PER_WORD = 8;

   // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_data_tx_fsm.sv
// Pops one FIFO record and sends it as comma-separated 8-digit hex words ending in CR LF.
// Talks to a byte-level UART TX core through a start pulse / done handshake.
module uart_data_tx_fsm
   import uart_data_pkg::*;
#(
   parameter int FIFO_RD_DATA_WIDTH = 96
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fsm_en,
   input  logic                          uart_tx_done,
   output logic                          uart_start_tx,
   output logic [7:0]                    uart_tx_din,
   input  logic [FIFO_RD_DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                          fifo_empty,
   output logic                          fifo_rd_en
);

   localparam int N          = FIFO_RD_DATA_WIDTH / WORD_BITS;
   localparam int WORD_CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(N - 1);
   localparam logic [2:0]            LAST_NIB  = 3'(NIBBLES_PER_WORD - 1);

   state_t                        state_q, state_d;
   logic                          done_q;
   logic                          done_evt;
   logic [2:0]                    nib_q, nib_d;
   logic [WORD_CNT_W-1:0]         word_q, word_d;
   logic [FIFO_RD_DATA_WIDTH-1:0] record_q;
   logic [FIFO_RD_DATA_WIDTH-1:0] rec_src;
   logic [FIFO_RD_DATA_WIDTH-1:0] rec_shifted;
   logic [3:0]                    cur_nib;
   logic [7:0]                    din_d;
   int                            shift_amt;

   // A held-high done level produces exactly one event.
   assign done_evt = uart_tx_done & ~done_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:            if (fsm_en && !fifo_empty) state_d = READ_FIFO;
         READ_FIFO:       state_d = UART_SEND_WORD;
         UART_SEND_WORD:  state_d = UART_WAIT_WORD;
         UART_WAIT_WORD: begin
            if (done_evt) begin
               if (nib_q != LAST_NIB)
                  state_d = UART_SEND_WORD;
               else if (word_q < LAST_WORD)
                  state_d = UART_SEND_COMMA;
               else
                  state_d = UART_SEND_CR;
            end
         end
         UART_SEND_COMMA: state_d = UART_WAIT_COMMA;
         UART_WAIT_COMMA: if (done_evt) state_d = UART_SEND_WORD;
         UART_SEND_CR:    state_d = UART_WAIT_CR;
         UART_WAIT_CR:    if (done_evt) state_d = UART_SEND_LF;
         UART_SEND_LF:    state_d = UART_WAIT_LF;
         UART_WAIT_LF:    if (done_evt) state_d = IDLE;
         default:         state_d = IDLE;
      endcase
   end

   // The pop is gated by reset so nothing is lost from the FIFO while held in reset.
   always_comb begin
      uart_start_tx = (state_q == UART_SEND_WORD)  || (state_q == UART_SEND_COMMA) ||
                      (state_q == UART_SEND_CR)    || (state_q == UART_SEND_LF);
      fifo_rd_en    = reset && (state_q == IDLE) && fsm_en && !fifo_empty;
   end

   always_comb begin
      nib_d  = nib_q;
      word_d = word_q;
      unique case (state_q)
         READ_FIFO: begin
            nib_d  = '0;
            word_d = '0;
         end
         UART_WAIT_WORD:  if (done_evt && nib_q != LAST_NIB) nib_d = nib_q + 3'd1;
         UART_WAIT_COMMA: begin
            if (done_evt) begin
               nib_d  = '0;
               word_d = word_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // The first digit is formed while the record is still on the FIFO bus.
   always_comb begin
      rec_src     = (state_q == READ_FIFO) ? fifo_rd_data : record_q;
      shift_amt   = WORD_BITS * (N - 1 - int'(word_d)) + 4 * (LAST_NIB - int'(nib_d));
      rec_shifted = rec_src >> shift_amt;
      cur_nib     = rec_shifted[3:0];
   end

   always_comb begin
      din_d = uart_tx_din;
      unique case (state_d)
         UART_SEND_WORD:  din_d = nibble_to_ascii(cur_nib);
         UART_SEND_COMMA: din_d = ASCII_COMMA;
         UART_SEND_CR:    din_d = ASCII_CR;
         UART_SEND_LF:    din_d = ASCII_LF;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q      <= 1'b0;
         nib_q       <= '0;
         word_q      <= '0;
         record_q    <= '0;
         uart_tx_din <= '0;
      end else begin
         done_q      <= uart_tx_done;
         nib_q       <= nib_d;
         word_q      <= word_d;
         uart_tx_din <= din_d;
         if (state_q == READ_FIFO)
            record_q <= fifo_rd_data;
      end
   end

endmodule

// File: tb/tb_uart_data_tx_fsm.sv
// Bench for uart_data_tx_fsm: a FIFO model, a UART responder with random done timing,
// and a text-level model that predicts every transmitted byte of each record.
module tb_uart_data_tx_fsm;
   import uart_data_pkg::*;

   localparam int W         = 96;
   localparam int N         = W / 32;
   localparam int REC_BYTES = 9 * N + 1;
   localparam int BUDGET    = 4000;
   localparam logic [W-1:0] REC_A = 96'hABCD0032839748AC8DFE3210;

   logic         clk = 1'b0;
   logic         reset;
   logic         fsm_en;
   logic         uart_tx_done = 1'b0;
   logic         uart_start_tx;
   logic [7:0]   uart_tx_din;
   logic [W-1:0] fifo_rd_data = '0;
   logic         fifo_empty = 1'b1;
   logic         fifo_rd_en;

   uart_data_tx_fsm #(.FIFO_RD_DATA_WIDTH(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .fsm_en        (fsm_en),
      .uart_tx_done  (uart_tx_done),
      .uart_start_tx (uart_start_tx),
      .uart_tx_din   (uart_tx_din),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Written only by the main sequence.
   logic [W-1:0] rec_mem [64];
   int  wr_ptr    = 0;
   int  hold_mode = 1;
   int  spur_cnt  = 0;
   bit  rsp_abort = 1'b0;

   // Written only by the agent process.
   logic [7:0] exp_q[$];
   logic [7:0] byte_log[$];
   int  rd_ptr      = 0;
   int  n_bytes     = 0;
   int  n_rd        = 0;
   int  pending     = 0;
   int  phase       = 0;
   int  delay_cnt   = 0;
   int  hold_cnt    = 0;
   int  spur_served = 0;
   bit  pop_req     = 1'b0;
   bit  prev_start  = 1'b0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Text model: hex digits of each 32-bit word, most significant word first, commas between, CR LF at end.
   function automatic void push_expected(input logic [W-1:0] rec);
      for (int w = N - 1; w >= 0; w--) begin
         logic [31:0] word;
         word = 32'(rec >> (32 * w));
         for (int k = 7; k >= 0; k--) begin
            int v;
            v = int'((word >> (4 * k)) & 32'hF);
            exp_q.push_back((v < 10) ? 8'(48 + v) : 8'(65 + v - 10));
         end
         if (w > 0) exp_q.push_back(8'h2C);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // Monitor on the falling edge, FIFO and UART responses just after the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_start_tx) begin
            check("start_single_cycle", prev_start, 1'b0);
            check("start_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("byte", uart_tx_din, exp_q.pop_front());
            byte_log.push_back(uart_tx_din);
            n_bytes++;
            pending++;
         end
         if (fifo_rd_en) begin
            n_rd++;
            pop_req = 1'b1;
         end
         prev_start = uart_start_tx;

         @(posedge clk);
         #1;
         if (rsp_abort) begin
            exp_q.delete();
            pending      = 0;
            phase        = 0;
            pop_req      = 1'b0;
            uart_tx_done = 1'b0;
         end else begin
            if (pop_req) begin
               fifo_rd_data = rec_mem[rd_ptr % 64];
               push_expected(rec_mem[rd_ptr % 64]);
               rd_ptr++;
               pop_req = 1'b0;
            end
            case (phase)
               0: begin
                  if (spur_served != spur_cnt) begin
                     spur_served++;
                     uart_tx_done = 1'b1;
                     hold_cnt     = 1;
                     phase        = 2;
                  end else if (pending > 0) begin
                     pending--;
                     delay_cnt = $urandom_range(0, 2);
                     phase     = 1;
                  end
               end
               1: begin
                  if (delay_cnt == 0) begin
                     uart_tx_done = 1'b1;
                     hold_cnt     = (hold_mode == 3) ? int'($urandom_range(1, 3)) : hold_mode;
                     phase        = 2;
                  end else begin
                     delay_cnt--;
                  end
               end
               default: begin
                  hold_cnt--;
                  if (hold_cnt <= 0) begin
                     uart_tx_done = 1'b0;
                     phase        = 0;
                  end
               end
            endcase
         end
         fifo_empty = (rd_ptr == wr_ptr);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_rec(input logic [W-1:0] rec);
      rec_mem[wr_ptr % 64] = rec;
      wr_ptr++;
   endtask

   function automatic bit drained();
      return (rd_ptr == wr_ptr) && (exp_q.size() == 0) && (phase == 0) && (pending == 0) && !pop_req;
   endfunction

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (!drained() && k < BUDGET) begin
         cyc(1);
         k++;
      end
      check({tag, "_finished_in_time"}, k < BUDGET, 1'b1);
      cyc(3);
      check({tag, "_state_idle"}, dut.state_q, IDLE);
   endtask

   task automatic wait_bytes(input string tag, input int target);
      int k;
      k = 0;
      while (n_bytes < target && k < BUDGET) begin
         cyc(1);
         k++;
      end
      check({tag, "_bytes_in_time"}, k < BUDGET, 1'b1);
   endtask

   task automatic check_text(input string tag, input int base, input string s);
      for (int i = 0; i < s.len(); i++)
         check(tag, (base + i < byte_log.size()) ? byte_log[base + i] : 8'hXX, s[i]);
      check({tag, "_cr"}, (base + 26 < byte_log.size()) ? byte_log[base + 26] : 8'hXX, 8'h0D);
      check({tag, "_lf"}, (base + 27 < byte_log.size()) ? byte_log[base + 27] : 8'hXX, 8'h0A);
   endtask

   initial begin
      int base_b;
      int base_rd;
      int acc;
      logic [W-1:0] rec_r;

      reset  = 1'b0;
      fsm_en = 1'b1;
      push_rec(REC_A);
      cyc(3);
      check("rst_start", uart_start_tx, 1'b0);
      check("rst_din", uart_tx_din, 8'h00);
      check("rst_rd_en_gated", fifo_rd_en, 1'b0);
      check("rst_state", dut.state_q, IDLE);

      // Directed record, one-cycle done pulses.
      base_b  = n_bytes;
      base_rd = n_rd;
      reset   = 1'b1;
      wait_drain("t1");
      check("t1_rd_count", n_rd - base_rd, 1);
      check("t1_byte_count", n_bytes - base_b, REC_BYTES);
      check_text("t1_text", base_b, "ABCD0032,839748AC,8DFE3210");

      // Done held high for two cycles per byte.
      hold_mode = 2;
      base_b    = n_bytes;
      push_rec(REC_A);
      wait_drain("t2");
      check("t2_byte_count", n_bytes - base_b, REC_BYTES);
      check_text("t2_text", base_b, "ABCD0032,839748AC,8DFE3210");

      // Empty FIFO with enable high: nothing starts.
      hold_mode = 1;
      acc       = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         acc += int'(fifo_rd_en) + int'(uart_start_tx);
      end
      check("empty_quiet", acc, 0);
      check("empty_state", dut.state_q, IDLE);

      // A done pulse while idle is ignored.
      base_b = n_bytes;
      spur_cnt++;
      cyc(6);
      check("spur_no_start", n_bytes - base_b, 0);
      check("spur_state", dut.state_q, IDLE);

      // Enable dropped mid-record: the record completes, the next one waits.
      base_b  = n_bytes;
      base_rd = n_rd;
      push_rec({$urandom, $urandom, $urandom});
      push_rec({$urandom, $urandom, $urandom});
      wait_bytes("en_drop", base_b + 3);
      fsm_en = 1'b0;
      acc    = 0;
      while (!(exp_q.size() == 0 && phase == 0 && pending == 0 && !pop_req) && acc < BUDGET) begin
         cyc(1);
         acc++;
      end
      check("en_drop_first_in_time", acc < BUDGET, 1'b1);
      cyc(20);
      check("en_drop_first_complete", n_bytes - base_b, REC_BYTES);
      check("en_drop_single_pop", n_rd - base_rd, 1);
      check("en_drop_state", dut.state_q, IDLE);
      fsm_en = 1'b1;
      wait_drain("en_resume");
      check("en_resume_pops", n_rd - base_rd, 2);
      check("en_resume_bytes", n_bytes - base_b, 2 * REC_BYTES);

      // Reset while waiting on a word digit.
      base_b  = n_bytes;
      base_rd = n_rd;
      push_rec({$urandom, $urandom, $urandom});
      rec_r = {$urandom, $urandom, $urandom};
      rec_r[W-1 -: 4] = 4'hA;
      push_rec(rec_r);
      wait_bytes("mid_rst", base_b + 3);
      check("mid_rst_in_wait_word", dut.state_q, UART_WAIT_WORD);
      #1;
      reset     = 1'b0;
      rsp_abort = 1'b1;
      #1;
      check("mid_rst_start", uart_start_tx, 1'b0);
      check("mid_rst_din", uart_tx_din, 8'h00);
      check("mid_rst_rd_en", fifo_rd_en, 1'b0);
      check("mid_rst_state", dut.state_q, IDLE);
      cyc(2);
      reset     = 1'b1;
      rsp_abort = 1'b0;
      base_b    = n_bytes;
      wait_drain("post_rst");
      check("post_rst_first_char", (base_b < byte_log.size()) ? byte_log[base_b] : 8'hXX, 8'h41);
      check("post_rst_bytes", n_bytes - base_b, REC_BYTES);
      check("post_rst_pops", n_rd - base_rd, 2);

      // All-zero record.
      base_b = n_bytes;
      push_rec('0);
      wait_drain("zero");
      check_text("zero_text", base_b, "00000000,00000000,00000000");

      // Random back-to-back records with random done hold lengths.
      hold_mode = 3;
      base_b    = n_bytes;
      base_rd   = n_rd;
      for (int i = 0; i < 6; i++) push_rec({$urandom, $urandom, $urandom});
      wait_drain("rand");
      check("rand_pops", n_rd - base_rd, 6);
      check("rand_bytes", n_bytes - base_b, 6 * REC_BYTES);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
